// File: rtl/axi_write_block.sv
// FIFO-to-AXI4-Lite write initiator: pops 32-bit words from the TX FIFO and writes them
// to consecutive word addresses, one AXI write transaction outstanding at a time.
module axi_write_block #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [LEN_WIDTH-1:0]    transfer_size,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic                    empty,
   output logic                    rd_en,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic                    busy,
   output logic                    done,
   output logic                    error
);

   localparam int CW = LEN_WIDTH - 2;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_XFER, S_RESP, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d, awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [CW-1:0]         words_q, words_d, idx_q, idx_d;
   logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d;
   logic                  bready_q, bready_d, busy_q, busy_d, error_q, error_d;

   logic [CW-1:0] words_in, idx_inc;
   logic          aw_fin, w_fin;

   assign words_in = transfer_size[LEN_WIDTH-1:2];
   assign idx_inc  = idx_q + CW'(1);
   // A channel counts as finished if it already dropped valid or handshakes this cycle.
   assign aw_fin   = !awvalid_q || awready;
   assign w_fin    = !wvalid_q  || wready;

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      words_d   = words_q;
      idx_d     = idx_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      busy_d    = busy_q;
      error_d   = error_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (words_in == '0) begin
                  state_d = S_DONE;
               end else begin
                  base_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
                  words_d = words_in;
                  idx_d   = '0;
                  error_d = 1'b0;
                  busy_d  = 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            if (!empty) state_d = S_LOAD;
         end
         S_LOAD: begin
            wdata_d   = data_in;
            awaddr_d  = base_q + ADDR_WIDTH'({idx_q, 2'b00});
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_XFER;
         end
         S_XFER: begin
            if (awvalid_q && awready) awvalid_d = 1'b0;
            if (wvalid_q && wready)   wvalid_d  = 1'b0;
            if (aw_fin && w_fin) begin
               bready_d = 1'b1;
               state_d  = S_RESP;
            end
         end
         S_RESP: begin
            if (bvalid && bready_q) begin
               bready_d = 1'b0;
               // Error response aborts; unsent words stay in the FIFO.
               if (bresp != 2'b00) begin
                  error_d = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_inc;
                  if (idx_inc == words_q) begin
                     busy_d  = 1'b0;
                     state_d = S_DONE;
                  end else begin
                     state_d = S_FETCH;
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         base_q    <= '0;
         words_q   <= '0;
         idx_q     <= '0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         busy_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         words_q   <= words_d;
         idx_q     <= idx_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         busy_q    <= busy_d;
         error_q   <= error_d;
      end
   end

   assign rd_en   = (state_q == S_FETCH) && !empty;
   assign done    = (state_q == S_DONE);
   assign awaddr  = awaddr_q;
   assign awvalid = awvalid_q;
   assign wdata   = wdata_q;
   assign wvalid  = wvalid_q;
   assign wstrb   = '1;
   assign bready  = bready_q;
   assign busy    = busy_q;
   assign error   = error_q;

endmodule
